// File: rtl/lfsr_period_meter.sv
// Period meter for a W-bit sample stream: captures a reference word on start, counts clocks
// until it recurs, and reports period, ones count on bit 0, and stuck/timeout flags.
module lfsr_period_meter #(
   parameter int unsigned W  = 8,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rs,
   input  logic          start,
   input  logic [W-1:0]  din,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] period,
   output logic [CW-1:0] ones,
   output logic          stuck,
   output logic          timeout
);

   localparam logic [CW-1:0] TC  = {CW{1'b1}};
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_COUNT = 1'b1
   } state_e;

   state_e        state_q;
   logic [W-1:0]  ref_q;
   logic [CW-1:0] k_q;
   logic [CW-1:0] acc_q;
   logic [CW-1:0] period_q;
   logic [CW-1:0] ones_q;
   logic          busy_q;
   logic          done_q;
   logic          stuck_q;
   logic          timeout_q;

   logic          match_c;
   logic [CW-1:0] acc_d;

   assign match_c = (din == ref_q);

   // Accumulator includes the current sample's bit 0 and saturates at the terminal count.
   assign acc_d = (acc_q == TC) ? TC : acc_q + CW'(din[0]);

   always_ff @(posedge clk) begin
      if (rs) begin
         state_q   <= S_IDLE;
         ref_q     <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         period_q  <= '0;
         ones_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         stuck_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  ref_q     <= din;
                  k_q       <= ONE;
                  acc_q     <= CW'(din[0]);
                  done_q    <= 1'b0;
                  stuck_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_COUNT;
               end
            end
            S_COUNT: begin
               // Recurrence wins over the terminal-count check on the same edge.
               if (match_c) begin
                  period_q <= k_q;
                  ones_q   <= acc_q;
                  stuck_q  <= (k_q == ONE);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else if (k_q == TC) begin
                  period_q  <= TC;
                  ones_q    <= acc_d;
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_IDLE;
               end else begin
                  k_q   <= k_q + ONE;
                  acc_q <= acc_d;
               end
            end
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign period  = period_q;
   assign ones    = ones_q;
   assign stuck   = stuck_q;
   assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_meter.sv
// Bench for lfsr_period_meter: two instances (CW=16 and CW=4) watch the same stream; results are
// compared with a reference model that scans the pre-generated stream for the first recurrence.
module tb_lfsr_period_meter;

   localparam int unsigned W   = 8;
   localparam int unsigned CWA = 16;
   localparam int unsigned CWB = 4;
   localparam int          L   = 300;

   logic           clk = 1'b0;
   logic           rs;
   logic           start;
   logic [W-1:0]   din;

   logic           busy_a, done_a, stuck_a, timeout_a;
   logic [CWA-1:0] period_a, ones_a;
   logic           busy_b, done_b, stuck_b, timeout_b;
   logic [CWB-1:0] period_b, ones_b;

   int n_chk  = 0;
   int n_fail = 0;

   logic [W-1:0] s [L];

   always #5 clk = ~clk;

   lfsr_period_meter #(.W(W), .CW(CWA)) u_a (
      .clk(clk), .rs(rs), .start(start), .din(din),
      .busy(busy_a), .done(done_a), .period(period_a), .ones(ones_a),
      .stuck(stuck_a), .timeout(timeout_a)
   );

   lfsr_period_meter #(.W(W), .CW(CWB)) u_b (
      .clk(clk), .rs(rs), .start(start), .din(din),
      .busy(busy_b), .done(done_b), .period(period_b), .ones(ones_b),
      .stuck(stuck_b), .timeout(timeout_b)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_flags_a"}, int'({busy_a, done_a, stuck_a, timeout_a}), 0);
      chk({tag, "_vals_a"},  int'({period_a, ones_a}), 0);
      chk({tag, "_flags_b"}, int'({busy_b, done_b, stuck_b, timeout_b}), 0);
      chk({tag, "_vals_b"},  int'({period_b, ones_b}), 0);
   endtask

   // Reference: first index k in 1..tc where the stream returns to s[0]; ones counted over the window.
   function automatic void model(input int cw, output int per, output int on,
                                 output int stk, output int tmo);
      int tc;
      int lim;
      int cnt;
      tc  = (1 << cw) - 1;
      per = tc;
      stk = 0;
      tmo = 1;
      cnt = 0;
      for (int k = 1; k <= tc && k < L; k++) begin
         if (s[k] == s[0]) begin
            per = k;
            tmo = 0;
            stk = (k == 1) ? 1 : 0;
            break;
         end
      end
      lim = tmo ? tc + 1 : per;
      for (int j = 0; j < lim && j < L; j++) cnt += int'(s[j][0]);
      on = (cnt > tc) ? tc : cnt;
   endfunction

   // Stream kinds: 0 constant, 1 offset mod-N counter, 2 maximal LFSR, 3 random repeating pattern.
   task automatic gen(input int kind, input int p0, input int p1);
      logic [W-1:0] pat [256];
      case (kind)
         0: for (int i = 0; i < L; i++) s[i] = 8'(p0);
         1: for (int i = 0; i < L; i++) s[i] = 8'(p0 + (i % p1));
         2: begin
            s[0] = 8'(p0);
            for (int i = 1; i < L; i++)
               s[i] = s[i-1][0] ? ((s[i-1] >> 1) ^ 8'hB8) : (s[i-1] >> 1);
         end
         default: begin
            for (int j = 0; j < 256; j++) pat[j] = 8'($urandom);
            for (int i = 0; i < L; i++) s[i] = pat[i % p1];
         end
      endcase
   endtask

   task automatic run(input string name, input bit b2b, input bit poke, input int abort_at);
      int  ep_a, eo_a, es_a, et_a;
      int  ep_b, eo_b, es_b, et_b;
      int  bc_a, bc_b, lat_a, lat_b, overlap;
      bit  seen_a, seen_b;
      bc_a = 0; bc_b = 0; lat_a = 0; lat_b = 0; overlap = 0;
      seen_a = 1'b0; seen_b = 1'b0;
      model(CWA, ep_a, eo_a, es_a, et_a);
      model(CWB, ep_b, eo_b, es_b, et_b);
      if (!b2b) @(negedge clk);
      din   = s[0];
      start = 1'b1;
      for (int i = 1; i < L; i++) begin
         @(negedge clk);
         if (i == 1) chk({name, "_ack"}, int'({busy_a, done_a, busy_b, done_b}), 10);
         if (abort_at == i) begin
            rs    = 1'b1;
            start = 1'b0;
            @(negedge clk);
            chk_zero({name, "_abort"});
            rs = 1'b0;
            return;
         end
         if (busy_a) bc_a++;
         if (busy_b) bc_b++;
         if ((busy_a && done_a) || (busy_b && done_b)) overlap++;
         if (done_a && !seen_a) begin
            seen_a = 1'b1;
            lat_a  = i;
            chk({name, "_per_a"},  int'(period_a), ep_a);
            chk({name, "_ones_a"}, int'(ones_a), eo_a);
            chk({name, "_flg_a"},  int'({stuck_a, timeout_a}), es_a * 2 + et_a);
         end
         if (done_b && !seen_b) begin
            seen_b = 1'b1;
            lat_b  = i;
            chk({name, "_per_b"},  int'(period_b), ep_b);
            chk({name, "_ones_b"}, int'(ones_b), eo_b);
            chk({name, "_flg_b"},  int'({stuck_b, timeout_b}), es_b * 2 + et_b);
         end
         if (seen_a && seen_b) break;
         din   = s[i];
         start = (poke && busy_a && busy_b) ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      start = 1'b0;
      chk({name, "_fin"},     int'(seen_a && seen_b), 1);
      chk({name, "_lat_a"},   lat_a, ep_a + 1);
      chk({name, "_lat_b"},   lat_b, ep_b + 1);
      chk({name, "_busy_a"},  bc_a, ep_a);
      chk({name, "_busy_b"},  bc_b, ep_b);
      chk({name, "_overlap"}, overlap, 0);
   endtask

   initial begin
      int kind;
      int p0;
      int p1;
      bit pk;

      rs    = 1'b1;
      start = 1'b1;
      din   = 8'($urandom);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk_zero($sformatf("rst%0d", c));
         din = 8'($urandom);
      end
      rs    = 1'b0;
      start = 1'b0;

      gen(0, 'h5A, 0);
      run("const", 1'b0, 1'b0, 0);
      chk("const_per",   int'(period_a), 1);
      chk("const_ones",  int'(ones_a), 0);
      chk("const_stuck", int'({stuck_a, timeout_a}), 2);

      gen(0, 'h77, 0);
      run("b2b", 1'b1, 1'b0, 0);
      chk("b2b_per",  int'(period_a), 1);
      chk("b2b_ones", int'(ones_a), 1);

      gen(1, 0, 10);
      run("mod10", 1'b0, 1'b1, 0);
      chk("mod10_per",  int'(period_a), 10);
      chk("mod10_ones", int'(ones_a), 5);
      chk("mod10_flg",  int'({stuck_a, timeout_a}), 0);

      gen(2, 1, 0);
      run("lfsr", 1'b0, 1'b0, 0);
      chk("lfsr_per",  int'(period_a), 255);
      chk("lfsr_ones", int'(ones_a), 128);
      chk("lfsr_flg",  int'({stuck_a, timeout_a}), 0);

      gen(1, 0, 256);
      run("tmo", 1'b0, 1'b0, 0);
      chk("tmo_per_b",  int'(period_b), 15);
      chk("tmo_ones_b", int'(ones_b), 8);
      chk("tmo_flg_b",  int'({stuck_b, timeout_b}), 1);
      chk("tmo_per_a",  int'(period_a), 256);

      gen(2, 1, 0);
      run("abort", 1'b0, 1'b0, 50);
      run("rerun", 1'b0, 1'b0, 0);
      chk("rerun_per", int'(period_a), 255);

      for (int r = 0; r < 24; r++) begin
         kind = int'($urandom_range(3, 0));
         p0   = int'($urandom_range(255, 0));
         p1   = 1;
         pk   = 1'($urandom_range(1, 0));
         case (kind)
            1: p1 = int'($urandom_range(256, 2));
            2: p0 = int'($urandom_range(255, 1));
            3: p1 = int'($urandom_range(250, 1));
            default: p1 = 1;
         endcase
         gen(kind, p0, p1);
         run($sformatf("rnd%0d_k%0d", r, kind), 1'b0, pk, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
